// File: rtl/llr_read_scheduler.sv
// rtl/llr_read_scheduler.sv - multi-beat LLR operand read scheduler for the SC polar decoder
//
// Accepts one node request at a time (the parent stage whose LLR vector is needed).
// It then issues one read beat per cycle to the internal LLR BRAM (dual port), or to
// the channel LLR buffer for the root stage. A valid/last/src/split strobe is
// delay-matched to the RAM read latency so the 2^P PEs know when operands are present.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         node request handshake (ready only when idle)
//   req_stage [SW]              parent stage to read, legal 1..N
//   pe_ready                    PE back-pressure; low holds the current beat
//   ram_rea/ram_rd_addra        BRAM port A read enable / address
//   ram_reb/ram_rd_addrb        BRAM port B read enable / address
//   ch_rd_en/ch_rd_addra/b      channel buffer read enable / alpha_a, alpha_b word addresses
//   opnd_valid/last/src/split   operand strobe aligned with RAM read data
//   done                        one-cycle pulse after the final operand
//   err                         one-cycle pulse on an illegal stage request
module llr_read_scheduler #(
    parameter int N       = 10,
    parameter int P       = 2,
    parameter int RAM_LAT = 1,
    localparam int SW     = $clog2(N + 1),
    localparam int AW     = $clog2((1 << (N - P)) - 2 + P),
    localparam int CW     = N - P,
    localparam int BW     = (N - P - 1 > 1) ? (N - P - 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [SW-1:0] req_stage,
    input  logic          pe_ready,
    output logic          ram_rea,
    output logic [AW-1:0] ram_rd_addra,
    output logic          ram_reb,
    output logic [AW-1:0] ram_rd_addrb,
    output logic          ch_rd_en,
    output logic [CW-1:0] ch_rd_addra,
    output logic [CW-1:0] ch_rd_addrb,
    output logic          opnd_valid,
    output logic          opnd_last,
    output logic          opnd_src,
    output logic          opnd_split,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t        state;

    // Per-node context latched on acceptance
    logic [AW-1:0] base_q;      // first word of the a-half
    logic [AW-1:0] off_q;       // distance from a-half word to b-half word
    logic [BW-1:0] j_q;         // current beat index
    logic [BW-1:0] jmax_q;      // index of the final beat (B-1)
    logic          src_q;       // 1 = channel buffer
    logic          split_q;     // 1 = halves on separate ports

    // Strobe registered alongside the read enables; feeds the latency pipe
    logic          iss_valid;
    logic          iss_last;
    logic          iss_src;
    logic          iss_split;

    // {valid, last, src, split} per stage
    logic [3:0]    pipe [RAM_LAT];

    // Request decode
    logic [31:0]   s_w;
    logic          dec_legal;
    logic [AW-1:0] dec_base;
    logic [AW-1:0] dec_off;
    logic [BW-1:0] dec_jmax;
    logic          dec_src;
    logic          dec_split;

    always_comb begin
        s_w       = 32'(req_stage);
        dec_legal = (s_w >= 32'd1) && (s_w <= 32'(N));
        dec_base  = '0;
        dec_off   = '0;
        dec_jmax  = '0;
        dec_src   = 1'b0;
        dec_split = 1'b1;
        if (s_w == 32'(N)) begin
            // Root stage: alpha_a in the lower half of the channel buffer, alpha_b in the upper half
            dec_src  = 1'b1;
            dec_off  = AW'(32'd1 << (N - P - 1));
            dec_jmax = BW'((32'd1 << (N - P - 1)) - 32'd1);
        end else if (s_w > 32'(P)) begin
            // Stage regions are stacked downward from the top of the BRAM
            dec_base = AW'((32'd1 << (N - P)) - (32'd1 << (s_w - 32'(P) + 32'd1)));
            dec_off  = AW'(32'd1 << (s_w - 32'(P) - 32'd1));
            dec_jmax = BW'((32'd1 << (s_w - 32'(P) - 32'd1)) - 32'd1);
        end else begin
            // Small stages fit both halves in one word; stage P sits lowest of the packed words
            dec_base  = AW'((32'd1 << (N - P)) - 32'd2 + 32'(P) - s_w);
            dec_split = 1'b0;
        end
    end

    // Beat addresses from the latched context
    logic [AW-1:0] j_aw;
    logic [CW-1:0] j_cw;
    logic [AW-1:0] nxt_addra;
    logic [AW-1:0] nxt_addrb;
    logic [CW-1:0] nxt_cha;
    logic [CW-1:0] nxt_chb;

    always_comb begin
        j_aw      = {{(AW - BW){1'b0}}, j_q};
        j_cw      = {{(CW - BW){1'b0}}, j_q};
        nxt_addra = base_q + j_aw;
        nxt_addrb = base_q + j_aw + off_q;
        nxt_cha   = j_cw;
        nxt_chb   = j_cw + off_q[CW-1:0];
    end

    assign opnd_valid = pipe[RAM_LAT-1][3];
    assign opnd_last  = pipe[RAM_LAT-1][2];
    assign opnd_src   = pipe[RAM_LAT-1][1];
    assign opnd_split = pipe[RAM_LAT-1][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            err          <= 1'b0;
            done         <= 1'b0;
            ram_rea      <= 1'b0;
            ram_reb      <= 1'b0;
            ch_rd_en     <= 1'b0;
            ram_rd_addra <= '0;
            ram_rd_addrb <= '0;
            ch_rd_addra  <= '0;
            ch_rd_addrb  <= '0;
            base_q       <= '0;
            off_q        <= '0;
            j_q          <= '0;
            jmax_q       <= '0;
            src_q        <= 1'b0;
            split_q      <= 1'b0;
            iss_valid    <= 1'b0;
            iss_last     <= 1'b0;
            iss_src      <= 1'b0;
            iss_split    <= 1'b0;
            for (int k = 0; k < RAM_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            // Enables and addresses are only non-zero on issue cycles
            err          <= 1'b0;
            done         <= 1'b0;
            ram_rea      <= 1'b0;
            ram_reb      <= 1'b0;
            ch_rd_en     <= 1'b0;
            ram_rd_addra <= '0;
            ram_rd_addrb <= '0;
            ch_rd_addra  <= '0;
            ch_rd_addrb  <= '0;
            iss_valid    <= 1'b0;
            iss_last     <= 1'b0;
            iss_src      <= 1'b0;
            iss_split    <= 1'b0;

            // The strobe enters the pipe the cycle the enable is visible, so it
            // exits exactly RAM_LAT cycles later together with the read data.
            pipe[0] <= {iss_valid, iss_last, iss_src, iss_split};
            for (int k = 1; k < RAM_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (dec_legal) begin
                            base_q    <= dec_base;
                            off_q     <= dec_off;
                            jmax_q    <= dec_jmax;
                            src_q     <= dec_src;
                            split_q   <= dec_split;
                            j_q       <= '0;
                            req_ready <= 1'b0;
                            state     <= S_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    if (pe_ready) begin
                        iss_valid <= 1'b1;
                        iss_last  <= (j_q == jmax_q);
                        iss_src   <= src_q;
                        iss_split <= split_q;
                        if (src_q) begin
                            ch_rd_en    <= 1'b1;
                            ch_rd_addra <= nxt_cha;
                            ch_rd_addrb <= nxt_chb;
                        end else begin
                            ram_rea      <= 1'b1;
                            ram_rd_addra <= nxt_addra;
                            if (split_q) begin
                                ram_reb      <= 1'b1;
                                ram_rd_addrb <= nxt_addrb;
                            end
                        end
                        if (j_q == jmax_q) begin
                            state <= S_DRAIN;
                        end else begin
                            j_q <= j_q + BW'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (opnd_valid && opnd_last) begin
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llr_read_scheduler.sv
// tb/tb_llr_read_scheduler.sv - scoreboard bench for llr_read_scheduler (N=5, P=1, RAM_LAT=1)
module tb_llr_read_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_stage = 3'd0;
    logic       pe_ready = 1'b1;
    logic       req_ready;
    logic       ram_rea, ram_reb, ch_rd_en;
    logic [3:0] ram_rd_addra, ram_rd_addrb, ch_rd_addra, ch_rd_addrb;
    logic       opnd_valid, opnd_last, opnd_src, opnd_split, done, err;

    always #5 clk = ~clk;

    llr_read_scheduler #(.N(5), .P(1), .RAM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_stage(req_stage),
        .pe_ready(pe_ready),
        .ram_rea(ram_rea), .ram_rd_addra(ram_rd_addra),
        .ram_reb(ram_reb), .ram_rd_addrb(ram_rd_addrb),
        .ch_rd_en(ch_rd_en), .ch_rd_addra(ch_rd_addra), .ch_rd_addrb(ch_rd_addrb),
        .opnd_valid(opnd_valid), .opnd_last(opnd_last), .opnd_src(opnd_src),
        .opnd_split(opnd_split), .done(done), .err(err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] issq[$];
    logic [63:0] opq[$];
    int          doneq[$];
    int          errq[$];
    int          n_pass = 0;
    int          n_total = 0;

    logic [31:0] pe_mask = 32'hFFFF_FFFF;
    int          pe_base = -100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // pe_ready for edge cyc+1 taken from the current request's mask
    initial begin
        forever begin
            int idx;
            @(negedge clk);
            idx = cyc + 1 - pe_base;
            pe_ready = (idx >= 0 && idx < 32) ? pe_mask[idx] : 1'b1;
        end
    end

    // Monitor: every visible output event pops its expected record
    initial begin
        forever begin
            logic [63:0] a;
            @(negedge clk);
            a = {cyc, 13'b0, ram_rea, ram_reb, ch_rd_en, ram_rd_addra, ram_rd_addrb, ch_rd_addra, ch_rd_addrb};
            if (ram_rea || ram_reb || ch_rd_en) begin
                if (issq.size() == 0) chk("unexpected_beat", a, 64'h0);
                else chk("beat", a, issq.pop_front());
            end else begin
                chk("idle_addr", {48'b0, ram_rd_addra, ram_rd_addrb, ch_rd_addra, ch_rd_addrb}, 64'h0);
            end
            if (opnd_valid) begin
                a = {cyc, 29'b0, opnd_last, opnd_src, opnd_split};
                if (opq.size() == 0) chk("unexpected_opnd", a, 64'h0);
                else chk("opnd", a, opq.pop_front());
            end
            if (done) begin
                if (doneq.size() == 0) chk("unexpected_done", {32'b0, cyc}, 64'h0);
                else chk("done", {32'b0, cyc}, {32'b0, doneq.pop_front()});
            end
            if (err) begin
                if (errq.size() == 0) chk("unexpected_err", {32'b0, cyc}, 64'h0);
                else chk("err", {32'b0, cyc}, {32'b0, errq.pop_front()});
            end
        end
    end

    // Issue one request; base/off/nb/src/split are hand-computed for N=5, P=1.
    // mask bit i is pe_ready on the i-th ISSUE cycle.
    task automatic start_req(input int stage, input int base, input int off, input int nb,
                             input bit src, input bit split, input logic [31:0] mask);
        int r, e, j;
        logic [3:0] ra, rb, ca, cb;
        @(negedge clk);
        r = cyc + 1;
        j = 0;
        e = r + 1;
        while (j < nb && (e - r - 1) < 32) begin
            if (mask[e - r - 1]) begin
                ra = src ? 4'd0 : 4'(base + j);
                rb = (src || !split) ? 4'd0 : 4'(base + j + off);
                ca = src ? 4'(j) : 4'd0;
                cb = src ? 4'(j + off) : 4'd0;
                issq.push_back({32'(e), 13'b0, !src, !src && split, src, ra, rb, ca, cb});
                opq.push_back({32'(e + 1), 29'b0, (j == nb - 1), src, split});
                if (j == nb - 1) doneq.push_back(e + 2);
                j++;
            end
            e++;
        end
        pe_mask   = mask;
        pe_base   = r + 1;
        req_stage = 3'(stage);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (req_ready && issq.size() == 0 && opq.size() == 0 && doneq.size() == 0) break;
        end
        chk("idle_reached", {31'b0, req_ready, 32'(issq.size() + opq.size() + doneq.size())},
            {31'b0, 1'b1, 32'd0});
    endtask

    task automatic bad_req(input int stage);
        @(negedge clk);
        errq.push_back(cyc + 1);
        req_stage = 3'(stage);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("err_req_ready", {63'b0, req_ready}, 64'h1);
        @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return {38'b0, req_ready, ram_rea, ram_reb, ch_rd_en, opnd_valid, opnd_last, opnd_src,
                opnd_split, done, err, ram_rd_addra, ram_rd_addrb, ch_rd_addra, ch_rd_addrb};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_outputs", all_outs(), 64'h1 << 25);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single-beat split read: stage 2 -> addra 12, addrb 13
        start_req(2, 12, 1, 1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_idle();

        // Packed stage 1 -> word 14 on port A only
        start_req(1, 14, 0, 1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        wait_idle();

        // Root stage from channel buffer, 8 beats; a stray request during ISSUE is ignored
        start_req(5, 0, 8, 8, 1'b1, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        req_stage = 3'd3;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        // Stage 4, 4 beats, pe_ready low on ISSUE cycles 2 and 3
        start_req(4, 0, 4, 4, 1'b0, 1'b1, 32'hFFFF_FFF9);
        wait_idle();

        // Stage 3, 2 beats at words 8..9 / 10..11
        start_req(3, 8, 2, 2, 1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_idle();

        // Illegal stages
        bad_req(0);
        bad_req(6);
        bad_req(7);

        // Reset mid-ISSUE aborts silently
        start_req(4, 0, 4, 4, 1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        issq.delete();
        opq.delete();
        doneq.delete();
        #1;
        chk("midreset_outputs", all_outs(), 64'h1 << 25);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("post_reset_ready", {63'b0, req_ready}, 64'h1);

        // Normal operation after the abort
        start_req(4, 0, 4, 4, 1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("queues_drained", 64'(issq.size() + opq.size() + doneq.size() + errq.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/llr_read_scheduler.md
Name: llr_read_scheduler

Overview:
- Multi-beat read scheduler for the LLR memory of the semi-parallel SC polar decoder.
- Accepts one node request at a time: the parent stage whose LLR vector must be read.
- Issues one or more dual-port read beats to the internal LLR BRAM, or to the channel LLR buffer for the root stage.
- Delay-matches a valid/last strobe to the RAM read latency so the 2^P processing elements know when operands are present; supports PE back-pressure.

Parameters:
N, 10, log2 code length; legal N >= P+2.
P, 2, log2 PE count; one memory word holds 2^P LLRs; legal P >= 1.
RAM_LAT, 1, read latency of LLR BRAM and channel buffer, in cycles; legal 1..4.
SW, $clog2(N+1), request stage width (localparam).
AW, $clog2(2^(N-P)-2+P), LLR BRAM address width (localparam).
CW, N-P, channel buffer address width (localparam).
BW, max(1,N-P-1), beat counter width (localparam).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  node request valid
req_ready  out  1  scheduler idle and able to accept a request
req_stage  in  SW  parent stage s to read, legal 1..N
pe_ready  in  1  PE can accept a beat; low stalls issue
ram_rea  out  1  BRAM port A read enable
ram_rd_addra  out  AW  BRAM port A address
ram_reb  out  1  BRAM port B read enable
ram_rd_addrb  out  AW  BRAM port B address
ch_rd_en  out  1  channel buffer read enable (both halves)
ch_rd_addra  out  CW  channel buffer alpha_a word address
ch_rd_addrb  out  CW  channel buffer alpha_b word address
opnd_valid  out  1  read data valid at RAM outputs this cycle
opnd_last  out  1  qualifies final beat of the node
opnd_src  out  1  0 = BRAM, 1 = channel buffer; qualified by opnd_valid
opnd_split  out  1  1 = a/b halves on ports A/B; 0 = both halves packed in port A word
done  out  1  one-cycle pulse after the last operand is valid
err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset: all outputs 0 except req_ready = 1. FSM goes to IDLE, beat counter 0, delay pipe cleared. Reset mid-operation aborts the node silently; no done is generated.
- Address map, stage t region in BRAM:
  - P < t <= N-1: words base(t) = 2^(N-P) - 2^(t-P+1) through base(t) + 2^(t-P) - 1.
  - 1 <= t <= P: single word at 2^(N-P) - 2 + (P - t).
  - Stage N lives in the channel buffer (2^(N-P) words).
- Beats per request: B(s) = 2^(s-1-P) if s >= P+1, else 1.
- Beat j addressing, j = 0..B-1:
  - s == N: ch_rd_en = 1, ch_rd_addra = j, ch_rd_addrb = j + 2^(N-P-1); ram_rea = ram_reb = 0.
  - P < s < N: ram_rea = ram_reb = 1, addra = base(s) + j, addrb = base(s) + j + 2^(s-1-P).
  - s <= P: ram_rea = 1, addra = packed word address; ram_reb = 0, addrb = 0; split = 0.
- Every read enable and address is registered. Enables are high only on issue cycles. Addresses return to 0 when no beat is issued.
- FSM states:
  - IDLE: req_ready = 1. On req_valid with legal stage: latch s, j = 0, go ISSUE; req_ready drops the next cycle. Illegal stage (0 or > N): err pulses next cycle, no read, stay IDLE.
  - ISSUE: when pe_ready = 1, issue beat j and increment j. On the beat with j == B-1, go DRAIN. When pe_ready = 0, issue nothing and hold j. pe_ready is sampled in the same cycle the beat would be registered.
  - DRAIN: wait until the last beat's strobe leaves the delay pipe. opnd_valid for beat j rises RAM_LAT+1 cycles after the issuing edge, i.e. RAM_LAT cycles after the enable is visible. Pulse done in the cycle after opnd_valid && opnd_last, then go IDLE with req_ready = 1.
- Delay pipe: RAM_LAT-stage shift register carrying {valid, last, src, split}, cleared on reset.
- Throughput: one beat per cycle when pe_ready is held high. Minimum request spacing is B + RAM_LAT + 2 cycles.
- req_valid while req_ready = 0 is ignored; the requester holds it.
- All address arithmetic is unsigned, truncated to AW/CW; legal parameters guarantee no overflow.

Test Plan:
- N=3,P=1,RAM_LAT=1, req_stage=2 -> one beat: ram_rea=ram_reb=1, addra=0, addrb=1; opnd_valid+last 2 cycles after the request edge; done the cycle after.
- N=3,P=1, req_stage=1 -> ram_rea=1, addra=2^(2)-2+0=2, ram_reb=0, opnd_split=0, single beat, done.
- N=5,P=1, req_stage=5 -> 8 channel beats: addra 0..7, addrb 8..15 on consecutive cycles; ram_re* stay 0; opnd_src=1; opnd_last only on the 8th valid.
- N=5,P=1, req_stage=4, pe_ready low for cycles 2-3 of ISSUE -> 4 beats at addra 0..3 / addrb 4..7, gap of 2 with j held; opnd_valid gaps mirror the stall.
- req_stage=0 and req_stage=N+1 -> err pulse, no enables, req_ready stays 1; request during ISSUE is ignored.
- rst_n asserted mid-ISSUE -> all outputs 0 immediately, req_ready=1 after release, no done; next request behaves normally.
